// File: rtl/matmul_job_arbiter_pkg.sv
// Shared types and width helpers for the matmul job arbiter and its interfaces.
package matmul_job_arbiter_pkg;

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_ABORT} state_e;

  function automatic int id_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  function automatic int idx_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic int addr_w(input int nreq, input int m);
    return id_w(nreq) + 2 * idx_w(m);
  endfunction

endpackage

// File: rtl/matmul_job_arbiter_if.sv
// Requester-side and engine-side buses of the matmul job arbiter.
interface matmul_job_arbiter_if
  import matmul_job_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int M    = 4
) ();
  localparam int ID_W  = id_w(NREQ);
  localparam int M_LEN = idx_w(M);

  logic [NREQ-1:0]  req, gnt, job_done, job_err, res_stb, res_ack;
  logic [ID_W-1:0]  owner_id;
  logic             busy;
  logic [31:0]      res_data;
  logic [M_LEN-1:0] res_i, res_j;

  modport master (output req, res_ack,
                  input  gnt, owner_id, busy, job_done, job_err, res_data, res_i, res_j, res_stb);
  modport slave  (input  req, res_ack,
                  output gnt, owner_id, busy, job_done, job_err, res_data, res_i, res_j, res_stb);
endinterface

interface matmul_eng_if
  import matmul_job_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int M    = 4
) ();
  localparam int M_LEN = idx_w(M);
  localparam int AW    = addr_w(NREQ, M);

  logic             eng_start, eng_rst, eng_done;
  logic [M_LEN-1:0] eng_a_i, eng_a_j, eng_b_i, eng_b_j, eng_z_i, eng_z_j;
  logic [31:0]      eng_z_out;
  logic             eng_z_stb, eng_z_ack;
  logic [AW-1:0]    mem_a_addr, mem_b_addr, mem_c_addr;

  modport master (output eng_start, eng_rst, eng_z_ack, mem_a_addr, mem_b_addr, mem_c_addr,
                  input  eng_done, eng_a_i, eng_a_j, eng_b_i, eng_b_j,
                         eng_z_out, eng_z_i, eng_z_j, eng_z_stb);
  modport slave  (input  eng_start, eng_rst, eng_z_ack, mem_a_addr, mem_b_addr, mem_c_addr,
                  output eng_done, eng_a_i, eng_a_j, eng_b_i, eng_b_j,
                         eng_z_out, eng_z_i, eng_z_j, eng_z_stb);
endinterface

// File: rtl/matmul_job_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from ptr+1 with wrap.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] pick,
  output logic [ID_W-1:0] idx,
  output logic            found
);
  logic [ID_W-1:0] cand;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found      = 1'b1;
        pick[cand] = 1'b1;
        idx        = cand;
      end
    end
  end
endmodule

// File: rtl/matmul_job_arbiter.sv
// Shares one matmul engine among NREQ requesters: round-robin grant, owner-tagged memory
// addresses, result routing to the owner, and a per-job cycle budget that aborts the engine.
module matmul_job_arbiter
  import matmul_job_arbiter_pkg::*;
#(
  parameter int M           = 4,
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  matmul_job_arbiter_if.slave  rq,
  matmul_eng_if.master         eng
);
  localparam int ID_W = id_w(NREQ);
  localparam int TW   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic [ID_W-1:0] owner_q, owner_d, ptr_q, ptr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [NREQ-1:0] pick, own_oh;
  logic [ID_W-1:0] pick_idx;
  logic            pick_vld, timeout, run;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_rr (
    .req   (rq.req),
    .ptr   (ptr_q),
    .pick  (pick),
    .idx   (pick_idx),
    .found (pick_vld)
  );

  assign own_oh  = NREQ'(1) << owner_q;
  assign run     = (state_q == S_RUN);
  assign timeout = (TIMEOUT_CYC != 0) && (timer_q == T_LAST);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    done_d  = '0;
    err_d   = '0;
    case (state_q)
      S_IDLE: if (pick_vld) begin
        gnt_d   = pick;
        owner_d = pick_idx;
        state_d = S_START;
      end
      S_START: begin
        timer_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        timer_d = timer_q + 1'b1;
        // Completion beats the budget when both land on the same cycle.
        if (eng.eng_done) begin
          done_d  = own_oh;
          gnt_d   = '0;
          ptr_d   = owner_q;
          state_d = S_IDLE;
        end else if (timeout) begin
          err_d   = own_oh;
          gnt_d   = '0;
          timer_d = '0;
          state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        // Timer reused to hold the engine in reset for two cycles.
        timer_d = timer_q + 1'b1;
        if (timer_q[0]) begin
          ptr_d   = owner_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= ID_W'(NREQ - 1);
      timer_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rq.gnt      = gnt_q;
  assign rq.owner_id = owner_q;
  assign rq.busy     = (state_q != S_IDLE);
  assign rq.job_done = done_q;
  assign rq.job_err  = err_q;
  assign rq.res_stb  = (run && eng.eng_z_stb) ? own_oh : '0;
  assign rq.res_data = eng.eng_z_out;
  assign rq.res_i    = eng.eng_z_i;
  assign rq.res_j    = eng.eng_z_j;

  assign eng.eng_start  = (state_q == S_START);
  assign eng.eng_rst    = !rst || (state_q == S_ABORT);
  assign eng.eng_z_ack  = run && rq.res_ack[owner_q];
  assign eng.mem_a_addr = {owner_q, eng.eng_a_i, eng.eng_a_j};
  assign eng.mem_b_addr = {owner_q, eng.eng_b_i, eng.eng_b_j};
  assign eng.mem_c_addr = {owner_q, eng.eng_z_i, eng.eng_z_j};

endmodule

// File: tb/tb_matmul_job_arbiter.sv
// Scoreboard bench: stimulus queues expected grant/done/err/result events, a monitor pops them.
module tb_matmul_job_arbiter;
  import matmul_job_arbiter_pkg::*;

  localparam int NREQ = 2;
  localparam int M    = 4;
  localparam int TO   = 16;
  localparam int K_GNT = 0, K_DONE = 1, K_ERR = 2, K_RES = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matmul_job_arbiter_if #(.NREQ(NREQ), .M(M)) rq ();
  matmul_eng_if         #(.NREQ(NREQ), .M(M)) eng ();

  matmul_job_arbiter #(.M(M), .NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .rq  (rq),
    .eng (eng)
  );

  typedef struct {
    int          kind;
    logic [63:0] v;
  } exp_t;

  exp_t expq[$];
  int   n_run = 0, n_fail = 0;
  int   lat = 10, start_cnt = 0, rst_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [63:0] v);
    exp_t e;
    e.kind = k;
    e.v    = v;
    expq.push_back(e);
  endtask

  task automatic observe(input int k, input logic [63:0] v);
    exp_t e;
    if (expq.size() == 0) begin
      n_run++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d val %0h want none", k, v);
    end else begin
      e = expq.pop_front();
      chk("event_kind", 64'(k), 64'(e.kind));
      chk($sformatf("event_val_k%0d", k), v, e.v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit hit(input int k);
    case (k)
      K_GNT:   return eng.eng_start === 1'b1;
      K_DONE:  return (|rq.job_done) === 1'b1;
      K_ERR:   return (|rq.job_err) === 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int k, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!hit(k) && n < 200);
    if (!hit(k)) begin
      n_run++;
      n_fail++;
      $display("FAIL wait_kind%0d: got no event within %0d cycles, want one", k, n);
    end
  endtask

  // Monitor: samples just after the falling edge, once inputs driven there have settled.
  initial forever begin
    @(negedge clk);
    #1;
    if (eng.eng_start === 1'b1) begin
      start_cnt++;
      observe(K_GNT, 64'({rq.owner_id, rq.gnt}));
    end
    if (rst === 1'b1 && eng.eng_rst === 1'b1) rst_cnt++;
    if ((|rq.job_done) === 1'b1) observe(K_DONE, 64'(rq.job_done));
    if ((|rq.job_err) === 1'b1) observe(K_ERR, 64'(rq.job_err));
    if ((|rq.res_stb) === 1'b1 && eng.eng_z_ack === 1'b1)
      observe(K_RES, 64'({eng.mem_c_addr, rq.res_i, rq.res_j, rq.res_data}));
  end

  // Stub engine: done (level) in the lat-th run cycle after accepting start; lat=0 never finishes.
  initial begin : engine
    int cnt;
    bit running;
    eng.eng_done = 1'b0;
    cnt = 0;
    running = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (eng.eng_rst === 1'b1) begin
        running = 1'b0;
        eng.eng_done = 1'b0;
      end else if (eng.eng_start === 1'b1) begin
        running = 1'b1;
        cnt = 0;
        eng.eng_done = 1'b0;
      end else if (running) begin
        cnt++;
        if (cnt == lat) begin
          eng.eng_done = 1'b1;
          running = 1'b0;
        end
      end
    end
  end

  initial begin
    int n, s0, r0;
    rst = 1'b0;
    rq.req = '0;
    rq.res_ack = '0;
    eng.eng_z_stb = 1'b0;
    eng.eng_z_out = '0;
    eng.eng_z_i = '0;
    eng.eng_z_j = '0;
    eng.eng_a_i = 2'd1;
    eng.eng_a_j = 2'd2;
    eng.eng_b_i = 2'd3;
    eng.eng_b_j = 2'd0;

    // reset state
    cyc(2);
    chk("rst_gnt", 64'(rq.gnt), 0);
    chk("rst_busy", 64'(rq.busy), 0);
    chk("rst_owner", 64'(rq.owner_id), 0);
    chk("rst_eng_rst", 64'(eng.eng_rst), 1);
    chk("rst_eng_start", 64'(eng.eng_start), 0);
    chk("rst_job_done", 64'(rq.job_done), 0);
    rst = 1'b1;
    cyc(1);

    // fairness: both requesting, order 0,1,0,1 with one idle cycle between jobs
    lat = 10;
    for (int i = 0; i < 4; i++) begin
      push(K_GNT, (i % 2 == 0) ? 64'h1 : 64'h6);
      push(K_DONE, (i % 2 == 0) ? 64'h1 : 64'h2);
    end
    rq.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_for(K_DONE, n);
      chk("fair_busy_idle", 64'(rq.busy), 0);
      if (i == 3) rq.req = '0;
      else begin
        cyc(1);
        chk("fair_gap_start", 64'(eng.eng_start), 1);
      end
    end

    // single job
    cyc(1);
    s0 = start_cnt;
    push(K_GNT, 64'h1);
    push(K_DONE, 64'h1);
    rq.req = 2'b01;
    wait_for(K_GNT, n);
    chk("single_gnt", 64'(rq.gnt), 64'h1);
    wait_for(K_DONE, n);
    chk("single_latency", 64'(n), 64'(lat + 1));
    rq.req = '0;
    chk("single_busy_low", 64'(rq.busy), 0);
    cyc(1);
    chk("single_done_pulse", 64'(rq.job_done), 0);
    chk("single_start_pulses", 64'(start_cnt - s0), 1);

    // routing to owner 1, non-owner ack ignored
    lat = 12;
    push(K_GNT, 64'h6);
    push(K_RES, 64'({5'h1B, 2'd2, 2'd3, 32'h3F80_0000}));
    push(K_DONE, 64'h2);
    rq.req = 2'b10;
    wait_for(K_GNT, n);
    cyc(2);
    eng.eng_z_stb = 1'b1;
    eng.eng_z_out = 32'h3F80_0000;
    eng.eng_z_i = 2'd2;
    eng.eng_z_j = 2'd3;
    rq.res_ack = 2'b01;
    #1;
    chk("route_stb", 64'(rq.res_stb), 64'h2);
    chk("route_data", 64'(rq.res_data), 64'h3F80_0000);
    chk("route_mem_c", 64'(eng.mem_c_addr), 64'h1B);
    chk("route_mem_a", 64'(eng.mem_a_addr), 64'h16);
    chk("route_mem_b", 64'(eng.mem_b_addr), 64'h1C);
    chk("route_nonowner_ack", 64'(eng.eng_z_ack), 0);
    cyc(2);
    chk("route_stall", 64'(eng.eng_z_ack), 0);
    rq.res_ack = 2'b10;
    #1;
    chk("route_owner_ack", 64'(eng.eng_z_ack), 1);
    @(posedge clk);
    #1;
    eng.eng_z_stb = 1'b0;
    rq.res_ack = '0;
    wait_for(K_DONE, n);
    rq.req = '0;

    // timeout on requester 0, then requester 1 served
    cyc(1);
    lat = 0;
    r0 = rst_cnt;
    push(K_GNT, 64'h1);
    push(K_ERR, 64'h1);
    push(K_GNT, 64'h6);
    push(K_DONE, 64'h2);
    rq.req = 2'b11;
    wait_for(K_GNT, n);
    wait_for(K_ERR, n);
    chk("to_run_cycles", 64'(n), 64'(TO + 1));
    chk("to_gnt_clear", 64'(rq.gnt), 0);
    chk("to_eng_rst_1", 64'(eng.eng_rst), 1);
    rq.req = 2'b10;
    lat = 10;
    cyc(1);
    chk("to_eng_rst_2", 64'(eng.eng_rst), 1);
    chk("to_err_pulse", 64'(rq.job_err), 0);
    cyc(1);
    chk("to_eng_rst_off", 64'(eng.eng_rst), 0);
    wait_for(K_DONE, n);
    rq.req = '0;
    chk("to_rst_cycles", 64'(rst_cnt - r0), 2);

    // done on the timeout cycle wins
    cyc(1);
    lat = TO;
    r0 = rst_cnt;
    push(K_GNT, 64'h1);
    push(K_DONE, 64'h1);
    rq.req = 2'b01;
    wait_for(K_GNT, n);
    wait_for(K_DONE, n);
    chk("race_latency", 64'(n), 64'(TO + 1));
    rq.req = '0;
    chk("race_no_err", 64'(rq.job_err), 0);
    cyc(1);
    chk("race_no_eng_rst", 64'(rst_cnt - r0), 0);

    // reset in the middle of a job
    lat = 0;
    push(K_GNT, 64'h1);
    rq.req = 2'b01;
    wait_for(K_GNT, n);
    cyc(3);
    chk("mrst_busy_before", 64'(rq.busy), 1);
    rst = 1'b0;
    #1;
    chk("mrst_eng_rst_comb", 64'(eng.eng_rst), 1);
    cyc(1);
    chk("mrst_gnt", 64'(rq.gnt), 0);
    chk("mrst_busy", 64'(rq.busy), 0);
    cyc(1);
    chk("mrst_eng_rst_hold", 64'(eng.eng_rst), 1);
    chk("mrst_no_done", 64'(rq.job_done), 0);
    rst = 1'b1;
    rq.req = '0;
    cyc(2);
    chk("mrst_idle_busy", 64'(rq.busy), 0);
    chk("mrst_eng_rst_off", 64'(eng.eng_rst), 0);

    chk("queue_empty", 64'(expq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
